// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - address map and STATUS layout for the data-side memory responder
package dmem_mmio_pkg;
    localparam logic [31:0] MMIO_BASE   = 32'h0000_0100;
    localparam logic [31:0] ADDR_LED    = 32'h0000_0100;
    localparam logic [31:0] ADDR_TIMER  = 32'h0000_0104;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0108;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_010C;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 5;

    function automatic logic [29:0] word_of(input logic [31:0] a);
        return a[31:2];
    endfunction
endpackage

// File: rtl/dmem_mmio_if.sv
// rtl/dmem_mmio_if.sv - load/store port plus TX byte stream between data_path and the responder
interface dmem_mmio_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output we, addr, write_data, tx_ready,
        input  read_data, led, tx_data, tx_valid
    );

    modport slave (
        input  we, addr, write_data, tx_ready,
        output read_data, led, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_sync_fifo.sv
// rtl/dmem_mmio_sync_fifo.sv - single-clock FIFO; dout reads 0 while empty so the head is never X
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - decoded data memory: RAM below 0x100, LED/TIMER/TXDATA/STATUS registers above
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_WORDS];
    logic [31:0]       r_led;
    logic [31:0]       r_timer;
    logic              r_ovf;

    logic [29:0]       w_word;
    logic              w_ram_hit;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_led_hit;
    logic              w_timer_hit;
    logic              w_tx_hit;
    logic              w_status_hit;
    logic              w_push_req;
    logic              w_ovf_clr;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [7:0]        w_dout;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_word       = word_of(bus.addr);
    assign w_ram_hit    = (bus.addr[31:8] == 24'd0) && ({26'd0, bus.addr[7:2]} < 32'(RAM_WORDS));
    assign w_ram_idx    = bus.addr[2 +: RAM_AW];
    assign w_led_hit    = (w_word == word_of(ADDR_LED));
    assign w_timer_hit  = (w_word == word_of(ADDR_TIMER));
    assign w_tx_hit     = (w_word == word_of(ADDR_TXDATA));
    assign w_status_hit = (w_word == word_of(ADDR_STATUS));
    assign w_unused     = &{1'b0, bus.addr[1:0], MMIO_BASE[0]};

    assign w_push_req = bus.we && w_tx_hit;
    assign w_ovf_clr  = bus.we && w_status_hit && bus.write_data[STAT_OVF];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_req),
        .din   (bus.write_data[7:0]),
        .pop   (bus.tx_ready),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset && bus.we && w_ram_hit) r_ram[w_ram_idx] <= bus.write_data;
    end

    // A push refused because the FIFO was full outranks a same-cycle overflow clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led   <= '0;
            r_timer <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (bus.we && w_led_hit) r_led <= bus.write_data;
            r_timer <= (bus.we && w_timer_hit) ? bus.write_data : r_timer + 32'd1;
            if (w_push_req && w_full) r_ovf <= 1'b1;
            else if (w_ovf_clr)       r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status                                 = '0;
        w_status[STAT_FULL]                      = w_full;
        w_status[STAT_EMPTY]                     = w_empty;
        w_status[STAT_OVF]                       = r_ovf;
        w_status[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(w_count);
    end

    always_comb begin
        bus.read_data = '0;
        if (w_ram_hit)         bus.read_data = r_ram[w_ram_idx];
        else if (w_led_hit)    bus.read_data = r_led;
        else if (w_timer_hit)  bus.read_data = r_timer;
        else if (w_status_hit) bus.read_data = w_status;
    end

    assign bus.led      = r_led;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = w_dout;
endmodule
